instruction_memory_access: RTL and testbench

MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM control and data outputs of the execute stage: ALU result as address, store data, and the read, write, unsigned and size signals. It owns the data memory and performs byte, halfword and word loads and stores with sign or zero extension. It registers the MEM/WB pipeline register feeding write-back, and exposes a read-only debug port for the debug unit.

---
 rtl/instruction_memory_access.sv | 171 +++++++++++++++++
 tb/tb_instruction_memory_access.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_access.sv
// -----------------------------------------------------------------------------
// instruction_memory_access
// MEM stage of the 5-stage MIPS pipeline. Owns the data memory, performs
// byte/halfword/word loads and stores (sign or zero extended loads), and
// registers the MEM/WB pipeline register feeding write-back.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_enable                pipeline advance (0 = stall, no memory write)
//   i_WB_write, i_WB_mem_to_reg, i_write_reg   write-back controls, passed on
//   i_MEM_read, i_MEM_write load / store strobes
//   i_MEM_unsigned          1 = zero-extend load, 0 = sign-extend
//   i_MEM_byte_half_word    00 byte, 01 halfword, 1x word
//   i_ALU_result            byte address / pass-through value
//   i_data_to_write_in_MEM  store data (low bits for sub-word stores)
//   i_debug_addr            debug word address
//   o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result,
//   o_mem_data, o_misaligned  MEM/WB pipeline register
//   o_debug_data            combinational read of mem[i_debug_addr]
// -----------------------------------------------------------------------------
module instruction_memory_access #(
  parameter int NB_DATA     = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_WB_write,
  input  logic                   i_WB_mem_to_reg,
  input  logic                   i_MEM_read,
  input  logic                   i_MEM_write,
  input  logic                   i_MEM_unsigned,
  input  logic [1:0]             i_MEM_byte_half_word,
  input  logic [4:0]             i_write_reg,
  input  logic [NB_DATA-1:0]     i_ALU_result,
  input  logic [NB_DATA-1:0]     i_data_to_write_in_MEM,
  input  logic [NB_MEM_ADDR-1:0] i_debug_addr,
  output logic                   o_WB_write,
  output logic                   o_WB_mem_to_reg,
  output logic [4:0]             o_write_reg,
  output logic [NB_DATA-1:0]     o_ALU_result,
  output logic [NB_DATA-1:0]     o_mem_data,
  output logic                   o_misaligned,
  output logic [NB_DATA-1:0]     o_debug_data
);

  // Data memory. Kept in flops because the whole array is cleared in the
  // single reset cycle and is read combinationally on two ports.
  logic [NB_DATA-1:0] mem_q [MEM_DEPTH];

  logic [NB_MEM_ADDR-1:0] word_addr;
  logic [1:0]             lane;
  logic                   is_byte;
  logic                   is_half;
  logic                   is_word;
  logic                   misaligned;
  logic [NB_DATA-1:0]     rd_word;
  logic [7:0]             sel_byte;
  logic [15:0]            sel_half;
  logic [NB_DATA-1:0]     load_data;
  logic [3:0]             byte_en;
  logic [NB_DATA-1:0]     wr_data;
  logic                   write_en;

  // Upper address bits are dropped, so addresses wrap modulo MEM_DEPTH*4.
  assign word_addr = i_ALU_result[NB_MEM_ADDR+1:2];
  assign lane      = i_ALU_result[1:0];
  assign is_byte   = (i_MEM_byte_half_word == 2'b00);
  assign is_half   = (i_MEM_byte_half_word == 2'b01);
  assign is_word   = i_MEM_byte_half_word[1];  // 10 behaves like 11

  // Only an actual memory access can be misaligned.
  assign misaligned = (i_MEM_read | i_MEM_write) &
                      ((is_half & lane[0]) | (is_word & (lane != 2'b00)));

  // ---------------------------------------------------------------- load path
  assign rd_word = mem_q[word_addr];

  always_comb begin
    sel_byte  = 8'h00;
    load_data = '0;
    case (lane)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    if (i_MEM_read && !misaligned) begin
      if (is_byte) begin
        load_data = i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, sel_byte}
                                   : {{(NB_DATA-8){sel_byte[7]}}, sel_byte};
      end else if (is_half) begin
        load_data = i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, sel_half}
                                   : {{(NB_DATA-16){sel_half[15]}}, sel_half};
      end else begin
        load_data = rd_word;
      end
    end
  end

  // --------------------------------------------------------------- store path
  // Sub-word data is replicated across the word so each lane enable simply
  // picks its own byte; untouched lanes keep their contents (no RMW).
  always_comb begin
    byte_en = 4'b0000;
    wr_data = i_data_to_write_in_MEM;
    if (is_byte) begin
      byte_en[lane] = 1'b1;
      wr_data       = {4{i_data_to_write_in_MEM[7:0]}};
    end else if (is_half) begin
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{i_data_to_write_in_MEM[15:0]}};
    end else begin
      byte_en = 4'b1111;
    end
  end

  assign write_en = i_enable & i_MEM_write & ~misaligned;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (write_en) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) begin
          mem_q[word_addr][8*l +: 8] <= wr_data[8*l +: 8];
        end
      end
    end
  end

  assign o_debug_data = mem_q[i_debug_addr];

  // ------------------------------------------------------ MEM/WB pipeline reg
  logic               wb_write_q;
  logic               mem_to_reg_q;
  logic [4:0]         write_reg_q;
  logic [NB_DATA-1:0] alu_result_q;
  logic [NB_DATA-1:0] mem_data_q;
  logic               misaligned_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wb_write_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_reg_q  <= '0;
      alu_result_q <= '0;
      mem_data_q   <= '0;
      misaligned_q <= 1'b0;
    end else if (i_enable) begin
      wb_write_q   <= i_WB_write;
      mem_to_reg_q <= i_WB_mem_to_reg;
      write_reg_q  <= i_write_reg;
      alu_result_q <= i_ALU_result;
      mem_data_q   <= load_data;
      misaligned_q <= misaligned;
    end
  end

  assign o_WB_write      = wb_write_q;
  assign o_WB_mem_to_reg = mem_to_reg_q;
  assign o_write_reg     = write_reg_q;
  assign o_ALU_result    = alu_result_q;
  assign o_mem_data      = mem_data_q;
  assign o_misaligned    = misaligned_q;

endmodule

// File: tb/tb_instruction_memory_access.sv
module tb_instruction_memory_access;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_WB_write = 1'b0;
  logic        i_WB_mem_to_reg = 1'b0;
  logic        i_MEM_read = 1'b0;
  logic        i_MEM_write = 1'b0;
  logic        i_MEM_unsigned = 1'b0;
  logic [1:0]  i_MEM_byte_half_word = 2'b00;
  logic [4:0]  i_write_reg = 5'd0;
  logic [31:0] i_ALU_result = 32'd0;
  logic [31:0] i_data_to_write_in_MEM = 32'd0;
  logic [7:0]  i_debug_addr = 8'd0;
  logic        o_WB_write;
  logic        o_WB_mem_to_reg;
  logic [4:0]  o_write_reg;
  logic [31:0] o_ALU_result;
  logic [31:0] o_mem_data;
  logic        o_misaligned;
  logic [31:0] o_debug_data;

  always #5 i_clk = ~i_clk;

  instruction_memory_access dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_enable               (i_enable),
    .i_WB_write             (i_WB_write),
    .i_WB_mem_to_reg        (i_WB_mem_to_reg),
    .i_MEM_read             (i_MEM_read),
    .i_MEM_write            (i_MEM_write),
    .i_MEM_unsigned         (i_MEM_unsigned),
    .i_MEM_byte_half_word   (i_MEM_byte_half_word),
    .i_write_reg            (i_write_reg),
    .i_ALU_result           (i_ALU_result),
    .i_data_to_write_in_MEM (i_data_to_write_in_MEM),
    .i_debug_addr           (i_debug_addr),
    .o_WB_write             (o_WB_write),
    .o_WB_mem_to_reg        (o_WB_mem_to_reg),
    .o_write_reg            (o_write_reg),
    .o_ALU_result           (o_ALU_result),
    .o_mem_data             (o_mem_data),
    .o_misaligned           (o_misaligned),
    .o_debug_data           (o_debug_data)
  );

  typedef struct packed {
    logic        wbw;
    logic        mtr;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mem_b [0:1023];  // byte-addressed reference memory
  bit         mem_known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int wa);
    return {mem_b[4*wa+3], mem_b[4*wa+2], mem_b[4*wa+1], mem_b[4*wa]};
  endfunction

  // One pipeline cycle: check the debug port against the model (all earlier
  // stores have landed), then present the new EX/MEM inputs and predict.
  task automatic step(input bit rst, input bit en, input bit rd, input bit wr,
                      input bit uns, input logic [1:0] sz, input logic [31:0] alu,
                      input logic [31:0] data, input int dbg);
    exp_t        e;
    int          a;
    int          n;
    logic [31:0] v;
    bit          mis;
    @(negedge i_clk);
    if (mem_known) begin
      i_debug_addr = (dbg < 0) ? 8'($urandom_range(0, 255)) : 8'(dbg);
      #1;
      chk("debug_data", o_debug_data, mword(int'(i_debug_addr)));
    end
    i_reset                = rst;
    i_enable               = en;
    i_MEM_read             = rd;
    i_MEM_write            = wr;
    i_MEM_unsigned         = uns;
    i_MEM_byte_half_word   = sz;
    i_ALU_result           = alu;
    i_data_to_write_in_MEM = data;
    i_WB_write             = 1'($urandom);
    i_WB_mem_to_reg        = 1'($urandom);
    i_write_reg            = 5'($urandom);
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
      mem_known = 1;
    end else if (en) begin
      a   = int'(alu[9:0]);
      n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      mis = (rd || wr) && ((a % n) != 0);
      v   = 32'd0;
      if (rd && !mis) begin
        for (int i = 0; i < n; i++) v = v | (32'(mem_b[a+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      end
      if (wr && !mis) begin
        for (int i = 0; i < n; i++) mem_b[a+i] = data[8*i +: 8];
      end
      e.wbw  = i_WB_write;
      e.mtr  = i_WB_mem_to_reg;
      e.wreg = i_write_reg;
      e.alu  = alu;
      e.data = v;
      e.mis  = mis;
      exp_q.push_back(e);
    end
  endtask

  task automatic dbg_const(input int wa, input logic [31:0] val);
    i_debug_addr = 8'(wa);
    #1;
    chk("debug_const", o_debug_data, val);
  endtask

  // Monitor: every edge produces a MEM/WB value; enabled edges pop the next
  // prediction, stalled edges must hold, reset edges must clear.
  initial begin : monitor
    exp_t last;
    bit   rs;
    bit   es;
    last = '0;
    forever begin
      @(posedge i_clk);
      rs = i_reset;
      es = i_enable;
      @(negedge i_clk);
      if (rs) begin
        last = '0;
      end else if (es) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got none expected one");
        end else begin
          last = exp_q.pop_front();
        end
      end
      $display("txn rst=%0d en=%0d alu=%08h mem_data=%08h mis=%0d wreg=%0d",
               rs, es, o_ALU_result, o_mem_data, o_misaligned, o_write_reg);
      chk("WB_write",      32'(o_WB_write),      32'(last.wbw));
      chk("WB_mem_to_reg", 32'(o_WB_mem_to_reg), 32'(last.mtr));
      chk("write_reg",     32'(o_write_reg),     32'(last.wreg));
      chk("ALU_result",    o_ALU_result,         last.alu);
      chk("mem_data",      o_mem_data,           last.data);
      chk("misaligned",    32'(o_misaligned),    32'(last.mis));
    end
  end

  initial begin : driver
    // Reset with a store presented: the store must be discarded.
    step(1, 1, 0, 1, 0, 2'b11, 32'h10, 32'hDEADBEEF, -1);
    for (int k = 0; k < 256; k++) step(0, 1, 0, 0, 0, 2'b11, $urandom, $urandom, k);

    // Word store / load and debug visibility.
    step(0, 1, 0, 1, 0, 2'b11, 32'h10, 32'h12345678, 4);
    step(0, 1, 1, 0, 0, 2'b11, 32'h10, $urandom, 4);
    dbg_const(4, 32'h12345678);

    // Sub-word loads.
    step(0, 1, 1, 0, 0, 2'b00, 32'h13, $urandom, -1);  // lb  -> 00000012
    step(0, 1, 1, 0, 1, 2'b00, 32'h10, $urandom, -1);  // lbu -> 00000078
    step(0, 1, 0, 1, 0, 2'b00, 32'h11, 32'h80, -1);    // sb 0x80
    step(0, 1, 1, 0, 0, 2'b00, 32'h11, $urandom, -1);  // lb  -> FFFFFF80
    step(0, 1, 1, 0, 1, 2'b00, 32'h11, $urandom, -1);  // lbu -> 00000080
    step(0, 1, 1, 0, 0, 2'b01, 32'h12, $urandom, -1);  // lh  -> 00001234

    // Partial stores accumulate in one word.
    step(0, 1, 0, 1, 0, 2'b00, 32'h21, 32'hAA, 8);
    step(0, 1, 0, 1, 0, 2'b01, 32'h22, 32'hBEEF, 8);
    step(0, 1, 1, 0, 0, 2'b11, 32'h20, $urandom, 8);
    dbg_const(8, 32'hBEEFAA00);

    // Misaligned store / load, then aligned access clears the flag.
    step(0, 1, 0, 1, 0, 2'b11, 32'h21, 32'hCAFEF00D, 8);
    step(0, 1, 1, 0, 0, 2'b11, 32'h20, $urandom, 8);
    dbg_const(8, 32'hBEEFAA00);
    step(0, 1, 1, 0, 0, 2'b01, 32'h23, $urandom, -1);
    step(0, 1, 1, 0, 0, 2'b11, 32'h10, $urandom, -1);

    // Stall for 3 cycles with a store presented, then release it.
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 2'b11, 32'h30, 32'h55, 12);
    step(0, 1, 0, 1, 0, 2'b11, 32'h30, 32'h55, 12);
    step(0, 1, 1, 0, 0, 2'b11, 32'h30, $urandom, 12);
    dbg_const(12, 32'h00000055);

    // Randomized traffic over a narrow, wrapping address window.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), 2'($urandom),
           ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127)), $urandom, -1);
    end

    // Drain: idle stalled cycles so the last prediction gets compared.
    step(0, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0, -1);
    step(0, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0, -1);
    @(negedge i_clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
